multicycle_control_fsm: RTL and testbench
=========================================

# multicycle_control_fsm

Main control unit for the multicycle RV32I core. A Moore state machine sequences the shared datapath (one ALU, one unified instruction/data memory, PC and IR registers) across 3–5 cycles per instruction. It covers the subset the core supports: LW, SW, R-type ALU, I-type ALU, BEQ and JAL. It drives every datapath mux select and write enable, and flags unsupported encodings.

## Interface
Parameters:
- ILLEGAL_HALT, 1, when 1 the ILLEGAL state is terminal until reset; when 0 ILLEGAL lasts one cycle, then returns to FETCH (instruction skipped).

Ports:
- i_clk  in  1  clock; all state changes on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_op  in  7  IR[6:0] opcode
- i_funct3  in  3  IR[14:12]
- i_funct7b5  in  1  IR[30]
- i_zero  in  1  ALU zero flag (combinational from current ALU result)
- o_pcWrite  out  1  PC register load enable
- o_adrSrc  out  1  memory address: 0 = PC, 1 = ALUOut register
- o_memWrite  out  1  memory write enable
- o_irWrite  out  1  IR and OldPC load enable
- o_regWrite  out  1  register file write enable
- o_resultSrc  out  2  result mux: 00 = ALUOut register, 01 = memory data register, 10 = ALU result (direct)
- o_aluSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1 register
- o_aluSrcB  out  2  00 = rs2 register, 01 = immediate, 10 = constant 4
- o_aluControl  out  4  ADD 0000, SUB 1000, AND 0111, OR 0110, XOR 0100
- o_immSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
- o_retire  out  1  one-cycle pulse in the final cycle of each completed instruction
- o_illegal  out  1  high while in the ILLEGAL state
- o_state  out  4  current state encoding (debug and bench)

## Operation
- States and their encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10, ILLEGAL 11. Encodings 12–15 are unreachable; if reached, go to FETCH.
- Outputs are decoded combinationally from the state. The only exception is BEQ's o_pcWrite, which also depends on i_zero. Any signal not listed for a state is 0, and selects not listed are 00.
- FETCH:
  - adrSrc=0, irWrite=1, aluSrcA=00, aluSrcB=10, ADD, resultSrc=10, pcWrite=1.
  - Next state: DECODE.
- DECODE:
  - aluSrcA=01, aluSrcB=01, ADD (computes the branch target).
  - Next state by opcode: LW/SW → MEMADR, R_TYPE_ALU → EXECUTER, I_TYPE_ALU → EXECUTEI, B_TYPE → BEQ, JAL → JAL.
  - Any other opcode → ILLEGAL.
- Legality is checked in DECODE; an illegal encoding goes to ILLEGAL:
  - LW/SW: funct3 must be 010.
  - B_TYPE: funct3 must be 000.
  - R/I ALU: funct3 must be in {000, 100, 110, 111}.
  - R-type: funct7b5=1 is legal only with funct3 000.
- MEMADR: aluSrcA=10, aluSrcB=01, ADD. Next state: LW → MEMREAD, SW → MEMWRITE.
- MEMREAD: adrSrc=1, resultSrc=00. Next state: MEMWB.
- MEMWB: resultSrc=01, regWrite=1, retire=1. Next state: FETCH.
- MEMWRITE: adrSrc=1, resultSrc=00, memWrite=1, retire=1. Next state: FETCH.
- EXECUTER: aluSrcA=10, aluSrcB=00, aluControl={funct7b5, funct3}. Next state: ALUWB.
- EXECUTEI: aluSrcA=10, aluSrcB=01, aluControl={0, funct3}; funct7b5 is ignored, so no SUB. Next state: ALUWB.
- ALUWB: resultSrc=00, regWrite=1, retire=1. Next state: FETCH.
- BEQ: aluSrcA=10, aluSrcB=00, SUB, resultSrc=00, pcWrite=i_zero, retire=1. Next state: FETCH.
- JAL: aluSrcA=01, aluSrcB=10, ADD (rd value = OldPC+4), resultSrc=00, pcWrite=1. Next state: ALUWB. The jump target is the ALUOut value latched in DECODE.
- o_immSrc is decoded from i_op in every state:
  - I_TYPE_ALU and LW → 00
  - SW → 01
  - B_TYPE → 10
  - JAL → 11
  - others → 00
- ILLEGAL: illegal=1, no write enables. Next state: ILLEGAL if ILLEGAL_HALT=1, else FETCH.

## Timing
- Reset: at the rising edge where i_rst=1, state becomes FETCH.
- While i_rst=1, o_pcWrite, o_irWrite, o_memWrite, o_regWrite and o_retire are forced to 0; the other outputs follow the state decode.
- First fetch occurs in the first cycle with i_rst=0.
- Reset asserted mid-instruction aborts the instruction: no partial writes after the reset edge, and the FSM restarts at FETCH.
- Cycles per instruction:
  - LW 5
  - SW 4
  - R-type 4
  - I-type 4
  - BEQ 3
  - JAL 4
  - ILLEGAL: 2 + 1 (ILLEGAL_HALT=0)
- Opcode and funct inputs are sampled only in DECODE, MEMADR, EXECUTER/EXECUTEI and for immSrc. The IR holds them stable after FETCH.
- i_zero is used only in BEQ, in the same cycle it is produced.

## Test plan
- Reset, then release i_rst: state 0, all enables 0 during reset. In the first free cycle pcWrite=1 and irWrite=1; the next cycle state=1.
- LW (op 0000011, funct3 010): state sequence 0,1,2,3,4. memWrite never high, regWrite=1 and resultSrc=01 only in state 4, retire pulses once, immSrc=00.
- R-type SUB (op 0110011, funct3 000, funct7b5=1): sequence 0,1,6,8 with aluControl=1000 in state 6. The same instruction as I-type (op 0010011) gives aluControl=0000.
- BEQ with i_zero=1, then with i_zero=0: sequence 0,1,9 both times; pcWrite=1 in state 9 only when zero=1; immSrc=10.
- JAL: sequence 0,1,10,8. In state 10 pcWrite=1, aluSrcA=01, aluSrcB=10; in state 8 regWrite=1.
- Illegal opcode 0110111 with ILLEGAL_HALT=1: state 11 persists for 10 cycles, o_illegal=1, no enables. Asserting i_rst for one cycle gives FETCH.
- Illegal opcode 0110111 with ILLEGAL_HALT=0: state 11 for one cycle, then FETCH.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multicycle RV32I core: sequences the shared ALU,
// unified memory, PC and IR across 3-5 cycles per instruction.
module multicycle_control_fsm #(
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [6:0] i_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_zero,
  output logic       o_pcWrite,
  output logic       o_adrSrc,
  output logic       o_memWrite,
  output logic       o_irWrite,
  output logic       o_regWrite,
  output logic [1:0] o_resultSrc,
  output logic [1:0] o_aluSrcA,
  output logic [1:0] o_aluSrcB,
  output logic [3:0] o_aluControl,
  output logic [1:0] o_immSrc,
  output logic       o_retire,
  output logic       o_illegal,
  output logic [3:0] o_state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  state_t state_q, state_d;
  logic   alu_f3_ok;
  logic   pc_write, mem_write, ir_write, reg_write, retire;

  // Only ADD/SUB, XOR, OR and AND are implemented in the ALU.
  assign alu_f3_ok = (i_funct3 == 3'b000) || (i_funct3 == 3'b100) ||
                     (i_funct3 == 3'b110) || (i_funct3 == 3'b111);

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (i_op)
          OP_LW, OP_SW: state_d = (i_funct3 == 3'b010) ? S_MEMADR : S_ILLEGAL;
          OP_R:   state_d = (alu_f3_ok && (!i_funct7b5 || i_funct3 == 3'b000))
                            ? S_EXECUTER : S_ILLEGAL;
          OP_I:   state_d = alu_f3_ok ? S_EXECUTEI : S_ILLEGAL;
          OP_B:   state_d = (i_funct3 == 3'b000) ? S_BEQ : S_ILLEGAL;
          OP_JAL: state_d = S_JAL;
          default: state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_d = (i_op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_ILLEGAL:  state_d = ILLEGAL_HALT ? S_ILLEGAL : S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    pc_write     = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    reg_write    = 1'b0;
    retire       = 1'b0;
    o_adrSrc     = 1'b0;
    o_resultSrc  = 2'b00;
    o_aluSrcA    = 2'b00;
    o_aluSrcB    = 2'b00;
    o_aluControl = 4'b0000;
    o_illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write    = 1'b1;
        o_aluSrcB   = 2'b10;
        o_resultSrc = 2'b10;
        pc_write    = 1'b1;
      end
      S_DECODE: begin
        o_aluSrcA = 2'b01;
        o_aluSrcB = 2'b01;
      end
      S_MEMADR: begin
        o_aluSrcA = 2'b10;
        o_aluSrcB = 2'b01;
      end
      S_MEMREAD: o_adrSrc = 1'b1;
      S_MEMWB: begin
        o_resultSrc = 2'b01;
        reg_write   = 1'b1;
        retire      = 1'b1;
      end
      S_MEMWRITE: begin
        o_adrSrc  = 1'b1;
        mem_write = 1'b1;
        retire    = 1'b1;
      end
      S_EXECUTER: begin
        o_aluSrcA    = 2'b10;
        o_aluControl = {i_funct7b5, i_funct3};
      end
      S_EXECUTEI: begin
        o_aluSrcA    = 2'b10;
        o_aluSrcB    = 2'b01;
        o_aluControl = {1'b0, i_funct3};
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      S_BEQ: begin
        o_aluSrcA    = 2'b10;
        o_aluControl = 4'b1000;
        pc_write     = i_zero;
        retire       = 1'b1;
      end
      // Jump target was latched into ALUOut during DECODE; ALU now forms OldPC+4.
      S_JAL: begin
        o_aluSrcA = 2'b01;
        o_aluSrcB = 2'b10;
        pc_write  = 1'b1;
      end
      S_ILLEGAL: o_illegal = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    case (i_op)
      OP_SW:   o_immSrc = 2'b01;
      OP_B:    o_immSrc = 2'b10;
      OP_JAL:  o_immSrc = 2'b11;
      default: o_immSrc = 2'b00;
    endcase
  end

  // Reset suppresses every architectural write so an aborted instruction leaves no trace.
  assign o_pcWrite  = pc_write  & ~i_rst;
  assign o_memWrite = mem_write & ~i_rst;
  assign o_irWrite  = ir_write  & ~i_rst;
  assign o_regWrite = reg_write & ~i_rst;
  assign o_retire   = retire    & ~i_rst;
  assign o_state    = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: one instance per ILLEGAL_HALT setting,
// random instruction stream checked against an instruction-class reference model.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst_c, rst_h;
  logic [6:0] op_r;
  logic [2:0] f3_r;
  logic       f7_r, zero_r;

  logic       c_pcWrite, c_adrSrc, c_memWrite, c_irWrite, c_regWrite, c_retire, c_illegal;
  logic [1:0] c_resultSrc, c_aluSrcA, c_aluSrcB, c_immSrc;
  logic [3:0] c_aluControl, c_state;
  logic       h_pcWrite, h_adrSrc, h_memWrite, h_irWrite, h_regWrite, h_retire, h_illegal;
  logic [1:0] h_resultSrc, h_aluSrcA, h_aluSrcB, h_immSrc;
  logic [3:0] h_aluControl, h_state;
  logic [18:0] act_c, act_h;

  int vectors = 0;
  int miscompares = 0;
  int seq_q[$];
  logic [2:0] f3_pool [5] = '{3'b000, 3'b010, 3'b100, 3'b110, 3'b111};

  always #5 clk = ~clk;

  multicycle_control_fsm #(.ILLEGAL_HALT(1'b0)) dut_c (
    .i_clk(clk), .i_rst(rst_c), .i_op(op_r), .i_funct3(f3_r), .i_funct7b5(f7_r),
    .i_zero(zero_r), .o_pcWrite(c_pcWrite), .o_adrSrc(c_adrSrc), .o_memWrite(c_memWrite),
    .o_irWrite(c_irWrite), .o_regWrite(c_regWrite), .o_resultSrc(c_resultSrc),
    .o_aluSrcA(c_aluSrcA), .o_aluSrcB(c_aluSrcB), .o_aluControl(c_aluControl),
    .o_immSrc(c_immSrc), .o_retire(c_retire), .o_illegal(c_illegal), .o_state(c_state)
  );

  multicycle_control_fsm #(.ILLEGAL_HALT(1'b1)) dut_h (
    .i_clk(clk), .i_rst(rst_h), .i_op(op_r), .i_funct3(f3_r), .i_funct7b5(f7_r),
    .i_zero(zero_r), .o_pcWrite(h_pcWrite), .o_adrSrc(h_adrSrc), .o_memWrite(h_memWrite),
    .o_irWrite(h_irWrite), .o_regWrite(h_regWrite), .o_resultSrc(h_resultSrc),
    .o_aluSrcA(h_aluSrcA), .o_aluSrcB(h_aluSrcB), .o_aluControl(h_aluControl),
    .o_immSrc(h_immSrc), .o_retire(h_retire), .o_illegal(h_illegal), .o_state(h_state)
  );

  assign act_c = {c_pcWrite, c_adrSrc, c_memWrite, c_irWrite, c_regWrite, c_resultSrc,
                  c_aluSrcA, c_aluSrcB, c_aluControl, c_immSrc, c_retire, c_illegal};
  assign act_h = {h_pcWrite, h_adrSrc, h_memWrite, h_irWrite, h_regWrite, h_resultSrc,
                  h_aluSrcA, h_aluSrcB, h_aluControl, h_immSrc, h_retire, h_illegal};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (op=%b f3=%b f7=%b z=%b)",
               tag, act, exp, op_r, f3_r, f7_r, zero_r);
    end
  endtask

  // Expected state walk of one instruction, derived from its class and legality.
  function automatic void build_seq(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    bit alu_ok;
    alu_ok = (f3 == 0) || (f3 == 4) || (f3 == 6) || (f3 == 7);
    if (op == 7'b0000011 && f3 == 2)                    seq_q = '{0, 1, 2, 3, 4};
    else if (op == 7'b0100011 && f3 == 2)               seq_q = '{0, 1, 2, 5};
    else if (op == 7'b0110011 && alu_ok && (!f7 || f3 == 0)) seq_q = '{0, 1, 6, 8};
    else if (op == 7'b0010011 && alu_ok)                seq_q = '{0, 1, 7, 8};
    else if (op == 7'b1100011 && f3 == 0)               seq_q = '{0, 1, 9};
    else if (op == 7'b1101111)                          seq_q = '{0, 1, 10, 8};
    else                                                seq_q = '{0, 1, 11};
  endfunction

  function automatic logic [18:0] model_out(input int st, input logic [6:0] op,
      input logic [2:0] f3, input logic f7, input logic z, input logic rst);
    logic pcw, adr, memw, irw, regw, ret, ill;
    logic [1:0] rs, sa, sb, imm;
    logic [3:0] alu;
    {pcw, adr, memw, irw, regw, ret, ill} = '0;
    rs = 0; sa = 0; sb = 0; alu = 0;
    case (st)
      0:  begin irw = 1; sb = 2; rs = 2; pcw = 1; end
      1:  begin sa = 1; sb = 1; end
      2:  begin sa = 2; sb = 1; end
      3:  adr = 1;
      4:  begin rs = 1; regw = 1; ret = 1; end
      5:  begin adr = 1; memw = 1; ret = 1; end
      6:  begin sa = 2; alu = {f7, f3}; end
      7:  begin sa = 2; sb = 1; alu = {1'b0, f3}; end
      8:  begin regw = 1; ret = 1; end
      9:  begin sa = 2; alu = 4'b1000; pcw = z; ret = 1; end
      10: begin sa = 1; sb = 2; pcw = 1; end
      11: ill = 1;
      default: ;
    endcase
    if (op == 7'b0100011)      imm = 2'b01;
    else if (op == 7'b1100011) imm = 2'b10;
    else if (op == 7'b1101111) imm = 2'b11;
    else                       imm = 2'b00;
    if (rst) {pcw, memw, irw, regw, ret} = '0;
    return {pcw, adr, memw, irw, regw, rs, sa, sb, alu, imm, ret, ill};
  endfunction

  // Called at a falling edge: drives reset for the coming edge, checks, advances.
  task automatic step(input bit halt_dut, input int exp_st, input logic rst);
    if (halt_dut) rst_h = rst; else rst_c = rst;
    zero_r = 1'($urandom_range(0, 1));
    #1;
    if (halt_dut) begin
      check("state_h", 32'(h_state), 32'(exp_st));
      check("out_h", 32'(act_h), 32'(model_out(exp_st, op_r, f3_r, f7_r, zero_r, rst)));
    end else begin
      check("state_c", 32'(c_state), 32'(exp_st));
      check("out_c", 32'(act_c), 32'(model_out(exp_st, op_r, f3_r, f7_r, zero_r, rst)));
    end
    @(negedge clk);
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    op_r = op; f3_r = f3; f7_r = f7;
    build_seq(op, f3, f7);
    foreach (seq_q[k]) step(1'b0, seq_q[k], 1'b0);
  endtask

  initial begin
    logic [6:0] op;
    logic [2:0] f3;
    rst_c = 1'b1; rst_h = 1'b1;
    op_r = 7'b0000011; f3_r = 3'b010; f7_r = 1'b0; zero_r = 1'b0;
    @(negedge clk);
    step(1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b1);

    run_instr(7'b0000011, 3'b010, 1'b0);  // LW
    run_instr(7'b0110011, 3'b000, 1'b1);  // SUB
    run_instr(7'b0010011, 3'b000, 1'b1);  // ADDI, funct7b5 ignored
    run_instr(7'b1100011, 3'b000, 1'b0);  // BEQ
    run_instr(7'b1100011, 3'b000, 1'b0);
    run_instr(7'b1101111, 3'b101, 1'b1);  // JAL
    run_instr(7'b0110111, 3'b000, 1'b0);  // LUI is unsupported
    run_instr(7'b0110011, 3'b100, 1'b1);  // funct7b5 with XOR is illegal
    run_instr(7'b0000011, 3'b000, 1'b0);  // LB is unsupported

    // Reset landing on MEMWRITE must suppress the store.
    op_r = 7'b0100011; f3_r = 3'b010; f7_r = 1'b0;
    step(1'b0, 0, 1'b0);
    step(1'b0, 1, 1'b0);
    step(1'b0, 2, 1'b0);
    step(1'b0, 5, 1'b1);
    step(1'b0, 0, 1'b1);

    repeat (200) begin
      case ($urandom_range(0, 8))
        0: op = 7'b0000011;
        1: op = 7'b0100011;
        2: op = 7'b0110011;
        3: op = 7'b0010011;
        4: op = 7'b1100011;
        5: op = 7'b1101111;
        6: op = 7'b0110111;
        7: op = 7'($urandom_range(0, 127));
        default: op = 7'b1100111;
      endcase
      if ($urandom_range(0, 3) != 0) f3 = f3_pool[$urandom_range(0, 4)];
      else                           f3 = 3'($urandom_range(0, 7));
      run_instr(op, f3, 1'($urandom_range(0, 1)));
    end

    // Halting variant: ILLEGAL is sticky until reset.
    rst_c = 1'b1;
    op_r = 7'b0110111; f3_r = 3'b000; f7_r = 1'b0;
    step(1'b1, 0, 1'b1);
    step(1'b1, 0, 1'b0);
    step(1'b1, 1, 1'b0);
    repeat (10) step(1'b1, 11, 1'b0);
    step(1'b1, 11, 1'b1);
    op_r = 7'b0010011;
    step(1'b1, 0, 1'b0);
    step(1'b1, 1, 1'b0);
    step(1'b1, 7, 1'b0);
    step(1'b1, 8, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
